fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 32, PC and instruction-memory byte-address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; rst_n, in, 1, reset: asynchronous, active-low.
- imem_addr, out, ADDR_WIDTH, byte address to instruction memory (memory registers it; data returns next cycle).
- imem_inst, in, DATA_WIDTH, instruction-memory read data.
- redirect_valid, in, 1, branch/jump/trap redirect request.
- redirect_pc, in, ADDR_WIDTH, redirect target.
- id_valid, out, 1, decode-side entry available.
- id_ready, in, 1, decode accepts entry.
- id_pc, out, ADDR_WIDTH, PC of presented entry.
- id_inst, out, DATA_WIDTH, instruction of presented entry.
- id_fault, out, 1, presented entry is a misaligned-fetch fault.

Function
REQ-003 SHALL hold fetch_pc; imem_addr SHALL equal fetch_pc combinationally.
REQ-004 "Issue" in a cycle SHALL occur iff not halted and (count + inflight - pop) < 2, where count = buffer occupancy (0..2), inflight = issue occurred previous cycle and was not killed, pop = id_valid & id_ready.
REQ-005 On issue without redirect, fetch_pc SHALL advance by 4 at the clock edge, modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0).
REQ-006 The instruction for an address issued in cycle c SHALL be sampled from imem_inst in cycle c+1 and written to the buffer with its PC; id_valid SHALL assert in cycle c+2.
REQ-007 The buffer SHALL be a 2-entry in-order FIFO; id_pc/id_inst/id_fault SHALL show the head entry; an entry SHALL be removed only on pop.
REQ-008 While id_valid=1 and id_ready=0, id_pc/id_inst/id_fault SHALL remain stable.
REQ-009 With id_ready held 1 and no redirect, throughput SHALL be one instruction per cycle.
REQ-010 Simultaneous write and pop SHALL leave count unchanged; writing to a full buffer SHALL never occur (guaranteed by REQ-004).
REQ-011 redirect_valid=1 in cycle r SHALL: clear the buffer, kill any in-flight response (not written in r+1), ignore any pop in r, set fetch_pc to the target at the end of r; the first issue SHALL be in r+1 and the first id_valid in r+3.
REQ-012 redirect_valid has priority over all other events in the same cycle.
REQ-013 id_fault SHALL be 0 for every entry whose address was 4-byte aligned.

Reset
REQ-014 While rst_n=0: fetch_pc=RESET_PC, count=0, inflight=0, halted=0, id_valid=0, id_pc=0, id_inst=0, id_fault=0.
REQ-015 Reset assertion mid-operation SHALL discard buffer and in-flight data immediately; first issue SHALL be in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.

Configuration
REQ-016 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect_pc with [1:0]!=0 SHALL be issued unchanged; its entry SHALL carry id_fault=1, id_inst=0x0000_0013 (regardless of imem_inst), id_pc=redirect_pc; the unit SHALL then set halted=1 and issue nothing further until the next redirect, which clears halted.
REQ-017 Macro not defined: redirect_pc[1:0] SHALL be forced to 00; id_fault SHALL be constant 0; halted SHALL never set.

Verification
REQ-018 Reset release, imem models 1-cycle read, id_ready=1 -> id_pc 0x0,0x4,0x8,... one per cycle from cycle 2, id_inst matches memory words.
REQ-019 id_ready=0 for 5 cycles after first id_valid -> id_pc stays 0x0, count saturates at 2, imem_addr stops at 0x8; on release 0x0,0x4,0x8 delivered in order, none lost or duplicated.
REQ-020 Redirect to 0x100 while buffer full and one in flight -> old entries never presented; id_valid low in r+1,r+2; id_pc=0x100 in r+3.
REQ-021 fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0000_0000.
REQ-022 Redirect to 0x102: with FETCH_MISALIGN_TRAP_EN -> single entry id_pc=0x102, id_fault=1, id_inst=0x13, then no issue until redirect to 0x200 resumes; without -> id_pc=0x100, id_fault=0.
REQ-023 rst_n pulsed low with buffer full -> id_valid=0 during reset; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencer, 1-cycle imem, 2-entry in-order decode buffer; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect faults.
// Issue to id_valid is 2 cycles; with id_ready low, issue stops once buffered plus in-flight entries reach 2.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic                  id_fault
);
    localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  fault;
    } entry_t;

    entry_t                entry_q [2];
    entry_t                head;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  inflight;
    logic                  inflight_fault;
    logic                  halted;
    logic                  misalign;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  pop;
    logic                  issue;
    logic [2:0]            next_occ;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign misalign        = fetch_pc[1:0] != 2'b00;
`else
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    assign misalign        = 1'b0;
`endif

    assign imem_addr = fetch_pc;
    assign id_valid  = count != 2'd0;
    assign pop       = id_valid & id_ready;

    // Reserve a buffer slot for every outstanding fetch so a response never meets a full buffer.
    assign next_occ  = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue     = !halted && (next_occ < 3'd2);

    assign head     = entry_q[rd_ptr];
    assign id_pc    = head.pc;
    assign id_inst  = head.inst;
    assign id_fault = head.fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= '0;
            inflight       <= 1'b0;
            inflight_fault <= 1'b0;
            halted         <= 1'b0;
            count          <= 2'd0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Redirect flushes the buffer, kills the response arriving now and the fetch issued now.
            fetch_pc <= redirect_target;
            inflight <= 1'b0;
            halted   <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            inflight       <= issue;
            inflight_pc    <= fetch_pc;
            inflight_fault <= misalign;
            if (issue && misalign) begin
                halted <= 1'b1;
            end
            if (inflight) begin
                entry_q[wr_ptr].pc    <= inflight_pc;
                entry_q[wr_ptr].inst  <= inflight_fault ? NOP_INST : imem_inst;
                entry_q[wr_ptr].fault <= inflight_fault;
                wr_ptr                <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(inflight) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected entries queued as stimulus is driven, compared on every accepted pop.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pop_cnt  = 0;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_fault      (id_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    // Synchronous instruction memory: data for the address seen at an edge appears next cycle.
    always @(posedge clk) imem_inst <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: a, inst: mem_word(a), fault: 1'b0});
            a = a + 32'd4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
    endtask

    // Drives a one-cycle redirect and returns at mid-cycle of the redirect cycle.
    task automatic redirect_start(input logic [31:0] tgt);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        pop_cnt = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst_n    = 1'b0;
        id_ready = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_valid", 64'(id_valid), 64'd0);
        repeat (2) cyc();
        @(negedge clk);
        check("rst_hold_valid", 64'(id_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready && !redirect_valid) begin
            exp_t e;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", 64'(id_pc), 64'(e.pc));
                check("pop_inst", 64'(id_inst), 64'(e.inst));
                check("pop_fault", 64'(id_fault), 64'(e.fault));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) cyc();
        @(negedge clk);
        check("reset_valid", 64'(id_valid), 64'd0);
        check("reset_pc", 64'(id_pc), 64'd0);
        check("reset_inst", 64'(id_inst), 64'd0);
        check("reset_fault", 64'(id_fault), 64'd0);
        check("reset_addr", 64'(imem_addr), 64'd0);

        // Streaming from reset at one instruction per cycle.
        push_seq(32'h0, 16);
        cyc();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        pop_cnt  = 0;
        @(negedge clk);
        check("c0_addr", 64'(imem_addr), 64'h0);
        check("c0_valid", 64'(id_valid), 64'd0);
        step();
        check("c1_addr", 64'(imem_addr), 64'h4);
        check("c1_valid", 64'(id_valid), 64'd0);
        for (int i = 2; i < 12; i++) begin
            step();
            check("stream_valid", 64'(id_valid), 64'd1);
        end
        #1;
        check("stream_pops", 64'(pop_cnt), 64'd10);

        // Decode stall right after the first entry appears.
        do_reset();
        push_seq(32'h0, 12);
        cyc();
        rst_n   = 1'b1;
        pop_cnt = 0;
        step();
        for (int i = 2; i < 7; i++) begin
            step();
            check("stall_valid", 64'(id_valid), 64'd1);
            check("stall_pc", 64'(id_pc), 64'h0);
            check("stall_addr", 64'(imem_addr), 64'h8);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            id_ready = 1'b1;
            @(negedge clk);
            check("drain_valid", 64'(id_valid), 64'd1);
        end
        #1;
        check("drain_pops", 64'(pop_cnt), 64'd8);

        // Redirect while streaming, with a pop offered in the redirect cycle.
        redirect_start(32'h100);
        push_seq(32'h100, 8);
        step();
        check("rd1_valid", 64'(id_valid), 64'd0);
        check("rd1_addr", 64'(imem_addr), 64'h100);
        step();
        check("rd2_valid", 64'(id_valid), 64'd0);
        check("rd2_addr", 64'(imem_addr), 64'h104);
        step();
        check("rd3_valid", 64'(id_valid), 64'd1);
        check("rd3_pc", 64'(id_pc), 64'h100);
        repeat (4) step();
        #1;
        check("rd_pops", 64'(pop_cnt), 64'd5);

        // Address wrap at the top of the address space.
        redirect_start(32'hFFFF_FFF8);
        push_seq(32'hFFFF_FFF8, 8);
        step();
        check("wrap1_addr", 64'(imem_addr), 64'hFFFF_FFF8);
        step();
        check("wrap2_addr", 64'(imem_addr), 64'hFFFF_FFFC);
        step();
        check("wrap3_addr", 64'(imem_addr), 64'h0);
        check("wrap3_pc", 64'(id_pc), 64'hFFFF_FFF8);
        repeat (4) step();
        #1;
        check("wrap_pops", 64'(pop_cnt), 64'd5);

        // Misaligned redirect target.
        redirect_start(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_q.push_back('{pc: 32'h102, inst: 32'h13, fault: 1'b1});
        step();
        check("mis1_addr", 64'(imem_addr), 64'h102);
        step();
        step();
        check("mis3_valid", 64'(id_valid), 64'd1);
        check("mis3_fault", 64'(id_fault), 64'd1);
        check("mis3_inst", 64'(id_inst), 64'h13);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_valid", 64'(id_valid), 64'd0);
        end
        #1;
        check("mis_pops", 64'(pop_cnt), 64'd1);
`else
        push_seq(32'h100, 8);
        step();
        check("mis1_addr", 64'(imem_addr), 64'h100);
        step();
        step();
        check("mis3_valid", 64'(id_valid), 64'd1);
        check("mis3_pc", 64'(id_pc), 64'h100);
        check("mis3_fault", 64'(id_fault), 64'd0);
        repeat (3) step();
        #1;
        check("mis_pops", 64'(pop_cnt), 64'd4);
`endif
        redirect_start(32'h200);
        push_seq(32'h200, 8);
        repeat (3) step();
        check("resume_valid", 64'(id_valid), 64'd1);
        check("resume_pc", 64'(id_pc), 64'h200);
        repeat (2) step();
        #1;
        check("resume_pops", 64'(pop_cnt), 64'd3);

        // Reset pulse with the buffer full.
        cyc();
        id_ready = 1'b0;
        repeat (3) step();
        check("full_valid", 64'(id_valid), 64'd1);
        do_reset();
        check("rst_pc", 64'(id_pc), 64'd0);
        push_seq(32'h0, 8);
        cyc();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        pop_cnt  = 0;
        @(negedge clk);
        check("rr0_addr", 64'(imem_addr), 64'h0);
        check("rr0_valid", 64'(id_valid), 64'd0);
        step();
        step();
        check("rr2_valid", 64'(id_valid), 64'd1);
        check("rr2_pc", 64'(id_pc), 64'h0);
        repeat (3) step();
        #1;
        check("rr_pops", 64'(pop_cnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
